mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 79 +++++++
 tb/tb_mem_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports, the single memory port and busy status of mem_arbiter.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req, m0_we, m0_ready;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_ready;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
        output m0_ready, m0_rdata, m1_ready, m1_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester single-port memory arbiter with fixed read latency.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic clk,
    input logic reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    state_t        state, state_nx;
    logic [3:0]    cnt;
    logic          gnt, gnt_nx, we_q, any_req;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata0, rdata1;
`ifdef MEM_ARBITER_RR_EN
    logic ptr;
`endif
    assign any_req = bus.m0_req || bus.m1_req;
`ifdef MEM_ARBITER_RR_EN
    assign gnt_nx = !(bus.m0_req && (!bus.m1_req || !ptr));
`else
    assign gnt_nx = !bus.m0_req;
`endif
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (any_req ? ACCESS : IDLE) :
                   state == ACCESS ? WAIT :
                   state == WAIT   ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    end
    // WAIT covers LATENCY-1 counted cycles plus the cycle that captures mem_rdata
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            gnt     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
`ifdef MEM_ARBITER_RR_EN
            ptr     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                gnt     <= gnt_nx;
                we_q    <= gnt_nx ? bus.m1_we : bus.m0_we;
                addr_q  <= gnt_nx ? bus.m1_addr : bus.m0_addr;
                wdata_q <= gnt_nx ? bus.m1_wdata : bus.m0_wdata;
`ifdef MEM_ARBITER_RR_EN
                ptr     <= !gnt_nx;
`endif
            end
            if (state == ACCESS)
                cnt <= 4'(LATENCY - 1);
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == WAIT && cnt == 4'd0 && !we_q) begin
                if (gnt)
                    rdata1 <= bus.mem_rdata;
                else
                    rdata0 <= bus.mem_rdata;
            end
        end
    end
    assign bus.mem_en    = state == ACCESS;
    assign bus.mem_we    = state == ACCESS && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.m0_ready  = state == RESP && !gnt;
    assign bus.m1_ready  = state == RESP && gnt;
    assign bus.m0_rdata  = rdata0;
    assign bus.m1_rdata  = rdata1;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at LATENCY=2 (dut2) and LATENCY=1 (dut1).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rd_word = 32'h0;
    logic [31:0] p2 [2];
    logic [31:0] p1;
    int vec = 0, errs = 0;
    int en_cyc, en_cnt, we_cnt, bad_we, r0_cyc, r0_cnt, r1_cyc, r1_cnt;
    logic [31:0] en_addr, en_wdata;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) b2 ();
    mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    // memory model: read data valid exactly LATENCY cycles after mem_en, inverted junk otherwise
    always @(posedge clk) begin
        p2[0] <= (b2.mem_en && !b2.mem_we) ? rd_word : ~rd_word;
        p2[1] <= p2[0];
        p1    <= (b1.mem_en && !b1.mem_we) ? rd_word : ~rd_word;
    end
    assign b2.mem_rdata = p2[1];
    assign b1.mem_rdata = p1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch2(input int n);
        en_cyc = -1; en_cnt = 0; we_cnt = 0; bad_we = 0;
        r0_cyc = -1; r0_cnt = 0; r1_cyc = -1; r1_cnt = 0;
        for (int c = 1; c <= n; c++) begin
            tick();
            if (b2.mem_we && !b2.mem_en) bad_we++;
            if (b2.mem_en) begin
                en_cnt++;
                if (en_cyc < 0) begin en_cyc = c; en_addr = b2.mem_addr; en_wdata = b2.mem_wdata; end
                if (b2.mem_we) we_cnt++;
            end
            if (b2.m0_ready) begin r0_cnt++; if (r0_cyc < 0) r0_cyc = c; b2.m0_req = 1'b0; end
            if (b2.m1_ready) begin r1_cnt++; if (r1_cyc < 0) r1_cyc = c; b2.m1_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        {b2.m0_req, b2.m0_we, b2.m1_req, b2.m1_we} = '0;
        {b1.m0_req, b1.m0_we, b1.m1_req, b1.m1_we} = '0;
        b2.m0_addr = '0; b2.m0_wdata = '0; b2.m1_addr = '0; b2.m1_wdata = '0;
        b1.m0_addr = '0; b1.m0_wdata = '0; b1.m1_addr = '0; b1.m1_wdata = '0;
        reset = 1'b1;
        repeat (3) tick();
        vec++; if (b2.mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en: got %b want 0", b2.mem_en); end
        vec++; if (b2.mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we: got %b want 0", b2.mem_we); end
        vec++; if (b2.m0_ready !== 1'b0 || b2.m1_ready !== 1'b0) begin errs++; $display("FAIL rst_ready: got %b%b want 00", b2.m0_ready, b2.m1_ready); end
        vec++; if (b2.busy !== 1'b0 || b1.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b%b want 00", b2.busy, b1.busy); end
        vec++; if (b2.m0_rdata !== 32'h0 || b2.m1_rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h %h want 0 0", b2.m0_rdata, b2.m1_rdata); end
        reset = 1'b0;
        tick();
        vec++; if (b2.busy !== 1'b0) begin errs++; $display("FAIL idle_no_req: busy %b want 0", b2.busy); end
    endtask

    task automatic test_single_read();
        rd_word = 32'h12345678;
        b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 32'h40;
        watch2(8);
        vec++; if (en_cyc !== 1) begin errs++; $display("FAIL rd_en_cycle: got %0d want 1", en_cyc); end
        vec++; if (en_cnt !== 1) begin errs++; $display("FAIL rd_en_count: got %0d want 1", en_cnt); end
        vec++; if (en_addr !== 32'h40) begin errs++; $display("FAIL rd_addr: got %h want 00000040", en_addr); end
        vec++; if (we_cnt !== 0 || bad_we !== 0) begin errs++; $display("FAIL rd_we: got %0d/%0d want 0/0", we_cnt, bad_we); end
        vec++; if (r0_cyc !== 4 || r0_cnt !== 1) begin errs++; $display("FAIL rd_ready: got cyc %0d cnt %0d want 4 1", r0_cyc, r0_cnt); end
        vec++; if (r1_cnt !== 0) begin errs++; $display("FAIL rd_m1_ready: got %0d want 0", r1_cnt); end
        vec++; if (b2.m0_rdata !== 32'h12345678) begin errs++; $display("FAIL rd_data: got %h want 12345678", b2.m0_rdata); end
        vec++; if (b2.m1_rdata !== 32'h0) begin errs++; $display("FAIL rd_m1_rdata: got %h want 0", b2.m1_rdata); end
    endtask

    task automatic test_single_write();
        rd_word = 32'hCAFEF00D;
        b2.m1_req = 1'b1; b2.m1_we = 1'b1; b2.m1_addr = 32'h80; b2.m1_wdata = 32'hDEADBEEF;
        watch2(8);
        vec++; if (en_cyc !== 1 || we_cnt !== 1 || bad_we !== 0) begin errs++; $display("FAIL wr_en_we: got en %0d we %0d stray %0d want 1 1 0", en_cyc, we_cnt, bad_we); end
        vec++; if (en_addr !== 32'h80 || en_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_bus: got %h %h want 00000080 deadbeef", en_addr, en_wdata); end
        vec++; if (r1_cyc !== 4 || r0_cnt !== 0) begin errs++; $display("FAIL wr_ready: got m1 %0d m0 cnt %0d want 4 0", r1_cyc, r0_cnt); end
        vec++; if (b2.m1_rdata !== 32'h0) begin errs++; $display("FAIL wr_m1_rdata: got %h want 0", b2.m1_rdata); end
        vec++; if (b2.m0_rdata !== 32'h12345678) begin errs++; $display("FAIL wr_m0_rdata: got %h want 12345678", b2.m0_rdata); end
        vec++; if (b2.busy !== 1'b0) begin errs++; $display("FAIL wr_busy_after: got %b want 0", b2.busy); end
    endtask

    task automatic test_simultaneous();
        int order [3];
        int rc [3];
        int n = 0;
        int exp_order [3];
`ifdef MEM_ARBITER_RR_EN
        exp_order = '{0, 1, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        rd_word = 32'h00001111;
        b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 32'h10;
        b2.m1_req = 1'b1; b2.m1_we = 1'b0; b2.m1_addr = 32'h20;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if ((b2.m0_ready || b2.m1_ready) && n < 3) begin
                order[n] = b2.m1_ready ? 1 : 0;
                rc[n] = c;
                n++;
                if (n == 3) begin b2.m0_req = 1'b0; b2.m1_req = 1'b0; end
            end
        end
        vec++; if (n !== 3) begin errs++; $display("FAIL sim_grants: got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            vec++; if (i < n && order[i] !== exp_order[i]) begin errs++; $display("FAIL sim_order%0d: got m%0d want m%0d", i, order[i], exp_order[i]); end
        end
        vec++; if (n == 3 && (rc[0] !== 4 || rc[1] !== 9 || rc[2] !== 14)) begin errs++; $display("FAIL sim_spacing: got %0d %0d %0d want 4 9 14", rc[0], rc[1], rc[2]); end
    endtask

    task automatic test_early_drop();
        int rcyc = -1;
        rd_word = 32'hA5A50001;
        b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 32'h44;
        tick();
        tick();
        b2.m0_req = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            tick();
            if (b2.m0_ready && rcyc < 0) rcyc = c;
        end
        vec++; if (rcyc !== 4) begin errs++; $display("FAIL drop_ready: got %0d want 4", rcyc); end
        vec++; if (b2.m0_rdata !== 32'hA5A50001) begin errs++; $display("FAIL drop_rdata: got %h want a5a50001", b2.m0_rdata); end
    endtask

    task automatic test_reset_mid();
        rd_word = 32'h00000077;
        b2.m0_req = 1'b1; b2.m0_we = 1'b0; b2.m0_addr = 32'h48;
        tick();
        tick();
        vec++; if (b2.busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before: got %b want 1", b2.busy); end
        reset = 1'b1; b2.m0_req = 1'b0;
        tick();
        vec++; if (b2.busy !== 1'b0 || b2.mem_en !== 1'b0) begin errs++; $display("FAIL mid_idle: got busy %b en %b want 0 0", b2.busy, b2.mem_en); end
        vec++; if (b2.m0_rdata !== 32'h0) begin errs++; $display("FAIL mid_rdata: got %h want 0", b2.m0_rdata); end
        reset = 1'b0;
        watch2(8);
        vec++; if (r0_cnt !== 0 || r1_cnt !== 0 || en_cnt !== 0) begin errs++; $display("FAIL mid_after: got ready %0d/%0d en %0d want 0/0 0", r0_cnt, r1_cnt, en_cnt); end
    endtask

    task automatic test_min_latency();
        int ec [2];
        int rc [2];
        int ne = 0, nr = 0;
        rd_word = 32'h00000031;
        b1.m0_req = 1'b1; b1.m0_we = 1'b0; b1.m0_addr = 32'h50;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (b1.mem_en) begin if (ne < 2) ec[ne] = c; ne++; end
            if (b1.m0_ready) begin
                if (nr < 2) rc[nr] = c;
                nr++;
                if (nr == 2) b1.m0_req = 1'b0;
            end
        end
        vec++; if (ne !== 2 || nr !== 2) begin errs++; $display("FAIL min_counts: got en %0d ready %0d want 2 2", ne, nr); end
        vec++; if (ne >= 2 && (ec[0] !== 1 || ec[1] !== 5)) begin errs++; $display("FAIL min_en_spacing: got %0d %0d want 1 5", ec[0], ec[1]); end
        vec++; if (nr >= 2 && (rc[0] !== 3 || rc[1] !== 7)) begin errs++; $display("FAIL min_ready: got %0d %0d want 3 7", rc[0], rc[1]); end
        vec++; if (b1.m0_rdata !== 32'h00000031) begin errs++; $display("FAIL min_rdata: got %h want 00000031", b1.m0_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_simultaneous();
        test_early_drop();
        test_reset_mid();
        test_min_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
